// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the skew FIFO bank.
// Lane packing, pointer sizing and reset values.
package fifo_pkg;

  localparam int DEF_DEPTH_LOG2 = 5;
  localparam int PTR_W = DEF_DEPTH_LOG2 + 1;

  localparam logic RST_EMPTY = 1'b1;
  localparam logic RST_FLAG  = 1'b0;

  function automatic int lane_lo(
    input int k,
    input int bw
  );
    return k * bw;
  endfunction

  function automatic int ptr_width(
    input int dl2
  );
    return dl2 + 1;
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Per-lane data+valid delay chain for the systolic wavefront.
// STAGES=0 is a pure pass-through.
module skew_delay_line
  import fifo_pkg::*;
#(
  parameter int BWIDTH = 8,
  parameter int STAGES = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [BWIDTH-1:0] i_data,
  input  logic              i_vld,
  output logic [BWIDTH-1:0] o_data,
  output logic              o_vld,
  output logic              o_busy
);

  if (STAGES == 0) begin : g_pass
    logic w_unused;
    assign w_unused = i_clk ^ i_rst_n;
    assign o_data   = i_data;
    assign o_vld    = i_vld;
    assign o_busy   = RST_FLAG;
  end else begin : g_chain
    logic [BWIDTH-1:0] r_d [STAGES];
    logic [STAGES-1:0] r_v;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        for (int i = 0; i < STAGES; i++) begin
          r_d[i] <= '0;
        end
        r_v <= '0;
      end else begin
        r_d[0] <= i_data;
        r_v[0] <= i_vld;
        for (int i = 1; i < STAGES; i++) begin
          r_d[i] <= r_d[i-1];
          r_v[i] <= r_v[i-1];
        end
      end
    end

    assign o_data = r_d[STAGES-1];
    assign o_vld  = r_v[STAGES-1];

    // Busy = valid still travelling, not yet at the lane output.
    if (STAGES > 1) begin : g_busy
      assign o_busy = |r_v[STAGES-2:0];
    end else begin : g_nobusy
      assign o_busy = 1'b0;
    end
  end

endmodule

// File: rtl/skew_fifo_bank.sv
// Multi-lane operand FIFO bank with shared pointers, status flags
// and optional per-lane skew for a systolic array edge.
module skew_fifo_bank
  import fifo_pkg::*;
#(
  parameter int DEPTH      = 32,
  parameter int DEPTH_LOG2 = 5,
  parameter int BWIDTH     = 8,
  parameter int CHANNELS   = 32,
  parameter int AF_LEVEL   = DEPTH - 2
) (
  input  logic                         CLK,
  input  logic                         RSTn,
  input  logic                         PUSHE,
  input  logic                         POPE,
  input  logic                         SKEW_EN,
  input  logic                         CLR_ERR,
  input  logic [CHANNELS*BWIDTH-1:0]   D_in,
  output logic [CHANNELS*BWIDTH-1:0]   D_out,
  output logic [CHANNELS-1:0]          V_out,
  output logic                         IS_EMPTY,
  output logic                         IS_FULL,
  output logic                         ALMOST_FULL,
  output logic [DEPTH_LOG2:0]          COUNT,
  output logic                         OVF,
  output logic                         UDF,
  output logic                         DRAIN
);

  localparam int PW = ptr_width(DEPTH_LOG2);
  localparam int RW = CHANNELS * BWIDTH;
  localparam logic [PW-1:0] C_DEPTH = PW'(DEPTH);
  localparam logic [PW-1:0] C_AF    = PW'(AF_LEVEL);
  localparam logic [PW-1:0] C_ONE   = PW'(1);

  logic [RW-1:0]       r_mem [DEPTH];
  logic [PW-1:0]       r_wr_ptr;
  logic [PW-1:0]       r_rd_ptr;
  logic [PW-1:0]       r_count;
  logic [RW-1:0]       r_rd_data;
  logic                r_rd_vld;
  logic                r_ovf;
  logic                r_udf;

  logic [PW-1:0]       w_wr_nxt;
  logic [PW-1:0]       w_rd_nxt;
  logic                w_push;
  logic                w_pop;
  logic                w_ovf_set;
  logic                w_udf_set;
  logic [CHANNELS-1:0] w_busy;

  assign IS_EMPTY    = (r_count == '0);
  assign IS_FULL     = (r_count == C_DEPTH);
  assign ALMOST_FULL = (r_count >= C_AF);
  assign COUNT       = r_count;
  assign OVF         = r_ovf;
  assign UDF         = r_udf;

  // A pop frees a slot this cycle, so a full bank still takes the push.
  assign w_pop     = POPE && !IS_EMPTY;
  assign w_push    = PUSHE && (!IS_FULL || w_pop);
  assign w_ovf_set = PUSHE && !w_push;
  assign w_udf_set = POPE && IS_EMPTY;

  assign w_wr_nxt = w_push ? r_wr_ptr + C_ONE : r_wr_ptr;
  assign w_rd_nxt = w_pop  ? r_rd_ptr + C_ONE : r_rd_ptr;

  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= D_in;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_rd_data <= '0;
      r_rd_vld  <= RST_FLAG;
      r_ovf     <= RST_FLAG;
      r_udf     <= RST_FLAG;
    end else begin
      r_wr_ptr <= w_wr_nxt;
      r_rd_ptr <= w_rd_nxt;
      r_count  <= w_wr_nxt - w_rd_nxt;
      r_rd_vld <= w_pop;
      if (w_pop) begin
        r_rd_data <= r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];
      end
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (CLR_ERR) begin
        r_ovf <= 1'b0;
      end
      if (w_udf_set) begin
        r_udf <= 1'b1;
      end else if (CLR_ERR) begin
        r_udf <= 1'b0;
      end
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    localparam int LO = lane_lo(k, BWIDTH);
    logic [BWIDTH-1:0] w_d;
    logic              w_v;

    skew_delay_line #(
      .BWIDTH (BWIDTH),
      .STAGES (k)
    ) u_dl (
      .i_clk   (CLK),
      .i_rst_n (RSTn),
      .i_data  (r_rd_data[LO +: BWIDTH]),
      .i_vld   (r_rd_vld),
      .o_data  (w_d),
      .o_vld   (w_v),
      .o_busy  (w_busy[k])
    );

    assign D_out[LO +: BWIDTH] = SKEW_EN ? w_d : r_rd_data[LO +: BWIDTH];
    assign V_out[k]            = SKEW_EN ? w_v : r_rd_vld;
  end

  // Stage 0 counts as in flight only while later lanes still await it.
  assign DRAIN = (r_rd_vld && (CHANNELS > 1)) || (|w_busy);

endmodule
